clock_period_meter: RTL
=======================

Name: clock_period_meter

Overview:
- Measures the toggle interval of a slow square wave (e.g. a divided clock_out) in clock_in cycles and recovers the divide ratio that produced it.
- Sits beside clock dividers as a self-check and auto-calibration block.
- Reports the half period (edge to edge) and the full period (rising to rising).
- Also reports a lock flag for a stable ratio and a timeout flag for a stopped input.

Parameters:
- TIMEOUT_CYCLES, 1000000, cycles with no edge before timeout is declared; legal range 2 to 2^32-1.
- SYNC_STAGES, 2, synchronizer flops on signal_in; legal range 2 to 4.

Ports:
- clock_in  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- signal_in  input  1  measured square wave; may be asynchronous to clock_in
- enable  input  1  measurement enable; low forces IDLE
- half_period  output  32  clock_in cycles between the last two edges of either polarity
- full_period  output  32  sum of the last two half periods
- measure_valid  output  1  one-cycle pulse when half_period updates
- locked  output  1  last two captured half periods were equal
- timeout  output  1  no edge within TIMEOUT_CYCLES

Behaviour:
- One clock, clock_in. Reset is asynchronous, active-low, on reset_n.
- Reset values: all outputs 0, edge counter 0, synchronizer flops 0, state IDLE.
- Synchronizer and edge detect:
  - signal_in passes through SYNC_STAGES flops, then one history flop.
  - edge = last sync stage XOR history flop, so both polarities count.
  - Fixed input-to-detect latency of SYNC_STAGES+1 cycles. It does not affect measured intervals.
- Edge counter cnt:
  - Loads 0 on an edge cycle; otherwise increments.
  - Saturates at 32'hFFFFFFFF.
  - Captured value on an edge = cnt+1, so a divider toggling every N cycles reads N.
- State machine:
  - IDLE: counter held at 0, measure_valid=0, locked=0, timeout=0. half_period and full_period keep their last values. enable=1 -> ARM.
  - ARM: waits for the first edge. That edge is not captured and only starts cnt. Edge -> MEASURE1. cnt reaching TIMEOUT_CYCLES-1 -> TMO.
  - MEASURE1: next edge captures half_period=cnt+1, pulses measure_valid and stores prev_half. full_period is not updated. -> MEASURE.
  - MEASURE: each edge captures half_period=cnt+1, sets full_period=prev_half+(cnt+1) with 32-bit wrap, pulses measure_valid and updates prev_half.
    - locked set if new capture == prev_half; otherwise cleared.
    - cnt reaching TIMEOUT_CYCLES-1 with no edge -> TMO.
  - TMO: timeout=1, locked=0, no captures. The next edge clears timeout, restarts cnt and goes to MEASURE1; that edge is not captured.
- All outputs are registered. measure_valid, half_period, full_period and locked update together, the cycle after the edge is detected.
- enable low in any state -> IDLE next cycle. No partial capture; timeout and locked clear.
- Edge and timeout in the same cycle: the edge wins and timeout does not assert.
- reset_n assertion mid-measurement clears everything immediately. After release, the first edge is again not captured.

Test Plan:
- Drive from a divider at divide_by=5 on the same clock_in, enable=1 -> first measure_valid carries half_period=5. From the second capture onward: full_period=10, locked=1, pulses every 5 cycles.
- Switch the ratio from 5 to 8 while running -> one capture of an intermediate value, then half_period=8, full_period=16. locked drops on the first differing capture and returns after two equal 8s.
- TIMEOUT_CYCLES=20, stop signal_in after lock -> timeout=1 and locked=0 exactly 20 cycles after the last edge. Restarting the input clears timeout on the next edge; first valid on the following edge.
- Asynchronous signal_in at a high level of 37 cycles and a low level of 63 cycles -> alternating half_period 37/63 within ±1, full_period 100 within ±1, locked toggling per the equality rule.
- Pulse reset_n low for 1 cycle mid-period at divide_by=4 -> all outputs 0 at once. First post-reset edge is not captured; the second gives half_period=4.
- Drop enable for 3 cycles while locked -> locked=0 and measure_valid=0 during IDLE, values held. Re-enable -> first edge is not captured.

Source files
------------

// File: rtl/clock_period_meter.sv
// clock_period_meter
// Measures the toggle interval of a slow square wave in clock_in cycles.
// Reports the last half period (edge to edge, either polarity), the full
// period (sum of the last two halves), a lock flag when two consecutive halves
// match, and a timeout flag when the input stops toggling.
//
// Timing: an input transition is seen on the edge detector SYNC_STAGES+1
// cycles after it happens. The delay is the same for every edge, so measured
// intervals are unaffected. All outputs are registered and change together on
// the cycle after the edge is detected.

module clock_period_meter #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000,  // 2 .. 2^32-1
   parameter int unsigned SYNC_STAGES    = 2         // 2 .. 4
) (
   input  logic        clock_in,
   input  logic        reset_n,
   input  logic        signal_in,
   input  logic        enable,
   output logic [31:0] half_period,
   output logic [31:0] full_period,
   output logic        measure_valid,
   output logic        locked,
   output logic        timeout
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,  // disabled, counter parked at 0
      ST_ARM      = 3'd1,  // waiting for the first edge (not captured)
      ST_MEASURE1 = 3'd2,  // first capture pending, no previous half yet
      ST_MEASURE  = 3'd3,  // steady state, every edge captures
      ST_TMO      = 3'd4   // input stopped; next edge restarts
   } state_t;

   // Count value on the last cycle before timeout is declared.
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 32'd1);

   // ---------------------------------------------------------------------
   // Synchronizer and edge detector
   // ---------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   edge_det;

   // Bring signal_in into the clock_in domain, then keep one history bit.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge value of its neighbour; blocking here would collapse the chain.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], signal_in};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // Either polarity counts as an edge.
   assign edge_det = sync_q[SYNC_STAGES-1] ^ hist_q;

   // ---------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------
   state_t      state_q,   state_d;
   logic [31:0] cnt_q,     cnt_d;
   logic [31:0] half_q,    half_d;
   logic [31:0] full_q,    full_d;
   logic        valid_q,   valid_d;
   logic        locked_q,  locked_d;
   logic        timeout_q, timeout_d;

   logic [31:0] cnt_inc;   // saturating cnt+1, also the captured interval
   logic        tmo_hit;

   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
   assign tmo_hit = (cnt_q == TMO_LAST);

   // half_q doubles as the previous half period: it always holds the value
   // of the most recent capture, which is exactly what the lock compare and
   // the full-period sum need.

   // Next-state, counter and output logic.
   // NOTE: every variable gets a default before the case so no path leaves
   // one unassigned; a missed branch would otherwise infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      half_d    = half_q;
      full_d    = full_q;
      valid_d   = 1'b0;
      locked_d  = locked_q;
      timeout_d = timeout_q;

      if (!enable) begin
         // Disable wins over everything: no capture on this cycle, flags
         // drop, measured values are held.
         state_d   = ST_IDLE;
         cnt_d     = '0;
         locked_d  = 1'b0;
         timeout_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_d   = '0;
               state_d = ST_ARM;
            end

            ST_ARM: begin
               if (edge_det) begin
                  // First edge only starts the interval count.
                  cnt_d   = '0;
                  state_d = ST_MEASURE1;
               end else begin
                  cnt_d = cnt_inc;
                  if (tmo_hit) begin
                     state_d   = ST_TMO;
                     timeout_d = 1'b1;
                     locked_d  = 1'b0;
                  end
               end
            end

            ST_MEASURE1: begin
               if (edge_det) begin
                  // No valid previous half yet: full_period is left alone.
                  half_d   = cnt_inc;
                  valid_d  = 1'b1;
                  locked_d = 1'b0;
                  cnt_d    = '0;
                  state_d  = ST_MEASURE;
               end else begin
                  cnt_d = cnt_inc;
                  if (tmo_hit) begin
                     state_d   = ST_TMO;
                     timeout_d = 1'b1;
                     locked_d  = 1'b0;
                  end
               end
            end

            ST_MEASURE: begin
               if (edge_det) begin
                  half_d   = cnt_inc;
                  full_d   = half_q + cnt_inc;   // 32-bit wrap is intended
                  valid_d  = 1'b1;
                  locked_d = (cnt_inc == half_q);
                  cnt_d    = '0;
               end else begin
                  cnt_d = cnt_inc;
                  if (tmo_hit) begin
                     state_d   = ST_TMO;
                     timeout_d = 1'b1;
                     locked_d  = 1'b0;
                  end
               end
            end

            ST_TMO: begin
               if (edge_det) begin
                  // Restart: this edge is a fresh starting point, not a
                  // capture, since the interval behind it is meaningless.
                  timeout_d = 1'b0;
                  cnt_d     = '0;
                  state_d   = ST_MEASURE1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end

            default: begin
               state_d   = ST_IDLE;
               cnt_d     = '0;
               locked_d  = 1'b0;
               timeout_d = 1'b0;
            end
         endcase
      end
   end

   // Register state, counter and every output together.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         half_q    <= '0;
         full_q    <= '0;
         valid_q   <= 1'b0;
         locked_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         half_q    <= half_d;
         full_q    <= full_d;
         valid_q   <= valid_d;
         locked_q  <= locked_d;
         timeout_q <= timeout_d;
      end
   end

   assign half_period   = half_q;
   assign full_period   = full_q;
   assign measure_valid = valid_q;
   assign locked        = locked_q;
   assign timeout       = timeout_q;

endmodule
